// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter sharing one spi_master byte engine between N_REQ requesters, one chip select each.
// Optional build macro SPI_ARB_PRIO0_EN: requester 0 gets fixed top priority in IDLE.
module spi_txn_arbiter #(
    parameter int N_REQ        = 4,
    parameter int HOLD_TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] req_byte,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ack,
    output logic [N_REQ-1:0]   rsp_valid,
    output logic [7:0]         rsp_byte,
    output logic [N_REQ-1:0]   timeout_err,
    output logic               busy,
    output logic [2:0]         grant_idx,
    output logic               m_start,
    output logic [7:0]         m_tx_byte,
    input  logic               m_done,
    input  logic [7:0]         m_rx_byte,
    input  logic               m_ss,
    output logic [N_REQ-1:0]   cs_n
);

    localparam int CNT_W = $clog2(HOLD_TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    state_t           state;
    logic [2:0]       rr_ptr;
    logic             last_q;
    logic [CNT_W-1:0] hold_cnt;
    logic [7:0]       sel_byte;
    logic             sel_req;
    logic             sel_last;
    logic [2:0]       pick;
    logic [2:0]       rel_ptr;

    // Winner is the set bit at the smallest forward distance from the pointer.
    function automatic logic [2:0] rr_pick(input logic [N_REQ-1:0] r, input logic [2:0] p);
        int best;
        int d;
        rr_pick = '0;
        best    = N_REQ;
        for (int i = 0; i < N_REQ; i++) begin
            d = (i >= int'(p)) ? i - int'(p) : i + N_REQ - int'(p);
            if (r[i] && d < best) begin
                best    = d;
                rr_pick = 3'(i);
            end
        end
    endfunction

    function automatic logic [N_REQ-1:0] onehot(input logic [2:0] g);
        onehot = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (g == 3'(i)) onehot[i] = 1'b1;
        end
    endfunction

    function automatic logic [2:0] next_idx(input logic [2:0] g);
        next_idx = (int'(g) == N_REQ - 1) ? 3'd0 : g + 3'd1;
    endfunction

    always_comb begin
        sel_byte = '0;
        sel_req  = 1'b0;
        sel_last = 1'b0;
        cs_n     = '1;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_idx == 3'(i)) begin
                sel_byte = req_byte[8*i +: 8];
                sel_req  = req[i];
                sel_last = req_last[i];
                if (busy) cs_n[i] = m_ss;
            end
        end
    end

    always_comb begin
`ifdef SPI_ARB_PRIO0_EN
        pick    = req[0] ? 3'd0 : rr_pick({req[N_REQ-1:1], 1'b0}, rr_ptr);
        rel_ptr = (grant_idx == 3'd0) ? rr_ptr : next_idx(grant_idx);
`else
        pick    = rr_pick(req, rr_ptr);
        rel_ptr = next_idx(grant_idx);
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            last_q      <= 1'b0;
            hold_cnt    <= '0;
            req_ack     <= '0;
            rsp_valid   <= '0;
            rsp_byte    <= '0;
            timeout_err <= '0;
            busy        <= 1'b0;
            grant_idx   <= '0;
            m_start     <= 1'b0;
            m_tx_byte   <= '0;
        end else begin
            req_ack     <= '0;
            rsp_valid   <= '0;
            timeout_err <= '0;
            m_start     <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        grant_idx <= pick;
                        busy      <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    m_start   <= 1'b1;
                    m_tx_byte <= sel_byte;
                    req_ack   <= onehot(grant_idx);
                    last_q    <= sel_last;
                    state     <= WAIT;
                end
                WAIT: begin
                    if (m_done) begin
                        rsp_byte  <= m_rx_byte;
                        rsp_valid <= onehot(grant_idx);
                        if (last_q) begin
                            state  <= IDLE;
                            busy   <= 1'b0;
                            rr_ptr <= rel_ptr;
                        end else if (sel_req) begin
                            // Owner already holds its next byte: skip HOLD to keep byte-to-byte gap minimal.
                            state <= ISSUE;
                        end else begin
                            state    <= HOLD;
                            hold_cnt <= '0;
                        end
                    end
                end
                HOLD: begin
                    if (sel_req) begin
                        state <= ISSUE;
                    end else if (hold_cnt == CNT_W'(HOLD_TIMEOUT - 1)) begin
                        timeout_err <= onehot(grant_idx);
                        state       <= IDLE;
                        busy        <= 1'b0;
                        rr_ptr      <= rel_ptr;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Self-checking bench for spi_txn_arbiter: behavioural byte engine, response scoreboard, RR vector table.
module tb_spi_txn_arbiter;

    localparam int N       = 4;
    localparam int HT      = 8;
    localparam int ENG_LEN = 5;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [8*N-1:0] req_byte;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ack;
    logic [N-1:0]   rsp_valid;
    logic [7:0]     rsp_byte;
    logic [N-1:0]   timeout_err;
    logic           busy;
    logic [2:0]     grant_idx;
    logic           m_start;
    logic [7:0]     m_tx_byte;
    logic           m_done;
    logic [7:0]     m_rx_byte;
    logic           m_ss;
    logic [N-1:0]   cs_n;

    always #5 clk = ~clk;

    spi_txn_arbiter #(.N_REQ(N), .HOLD_TIMEOUT(HT)) dut (
        .clk(clk), .reset(reset), .req(req), .req_byte(req_byte), .req_last(req_last),
        .req_ack(req_ack), .rsp_valid(rsp_valid), .rsp_byte(rsp_byte), .timeout_err(timeout_err),
        .busy(busy), .grant_idx(grant_idx), .m_start(m_start), .m_tx_byte(m_tx_byte),
        .m_done(m_done), .m_rx_byte(m_rx_byte), .m_ss(m_ss), .cs_n(cs_n)
    );

    typedef struct { logic [2:0] idx; logic [7:0] rx; } rsp_t;
    typedef struct { logic [3:0] mask; logic [2:0] exp; } vec_t;

    rsp_t       sb[$];
    rsp_t       mon_e;
    vec_t       vec[10];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] rx_xor = 8'h00;
    int         eng_cnt;
    logic [7:0] eng_tx;

    // Byte engine: SS low for ENG_LEN cycles after m_start, then a one-cycle done with MISO = MOSI ^ rx_xor.
    always @(posedge clk) begin
        m_done <= 1'b0;
        if (reset) begin
            eng_cnt   <= 0;
            m_ss      <= 1'b1;
            m_rx_byte <= 8'h00;
        end else if (m_start) begin
            eng_cnt <= ENG_LEN;
            eng_tx  <= m_tx_byte;
            m_ss    <= 1'b0;
        end else if (eng_cnt != 0) begin
            eng_cnt <= eng_cnt - 1;
            if (eng_cnt == 1) begin
                m_done    <= 1'b1;
                m_rx_byte <= eng_tx ^ rx_xor;
                m_ss      <= 1'b1;
            end
        end
    end

    function automatic logic [3:0] oh(input int i);
        oh = 4'(1 << i);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [2:0] idx, input logic [7:0] rx);
        rsp_t e;
        e.idx = idx;
        e.rx  = rx;
        sb.push_back(e);
    endtask

    task automatic set_req(input int i, input logic [7:0] b, input logic last);
        req[i]          = 1'b1;
        req_byte[8*i+:8] = b;
        req_last[i]     = last;
    endtask

    task automatic add_vec(input int k, input logic [3:0] m, input logic [2:0] e);
        vec[k].mask = m;
        vec[k].exp  = e;
    endtask

    // which: 0 = any req_ack, 1 = busy low, 2 = m_done, 3 = m_ss low
    task automatic wait_cond(input string name, input int which, input int maxc);
        logic hit;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            case (which)
                0:       hit = (req_ack != '0);
                1:       hit = !busy;
                2:       hit = m_done;
                default: hit = !m_ss;
            endcase
            if (hit) return;
        end
        checks++;
        errors++;
        $display("FAIL %s: timed out after %0d cycles", name, maxc);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctrl"}, 32'({req_ack, rsp_valid, timeout_err, busy, grant_idx, m_start}), 32'h0);
        check({tag, "_data"}, 32'({rsp_byte, m_tx_byte}), 32'h0);
        check({tag, "_cs_n"}, 32'(cs_n), 32'hF);
    endtask

    // Scoreboard: every rsp_valid pulse must match the oldest expected response.
    always @(negedge clk) begin
        if (!reset && rsp_valid != '0) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got rsp_valid %b expected none", rsp_valid);
            end else begin
                mon_e = sb.pop_front();
                check("rsp_valid", 32'(rsp_valid), 32'(oh(int'(mon_e.idx))));
                check("rsp_byte", 32'(rsp_byte), 32'(mon_e.rx));
            end
        end
    end

    initial begin
        reset    = 1'b1;
        req      = '0;
        req_byte = '0;
        req_last = '0;
`ifdef SPI_ARB_PRIO0_EN
        add_vec(0, 4'b0101, 3'd0); add_vec(1, 4'b0101, 3'd0); add_vec(2, 4'b0100, 3'd2);
        add_vec(3, 4'b1111, 3'd0); add_vec(4, 4'b1110, 3'd3); add_vec(5, 4'b1110, 3'd1);
        add_vec(6, 4'b0110, 3'd2); add_vec(7, 4'b0001, 3'd0); add_vec(8, 4'b1010, 3'd3);
        add_vec(9, 4'b0110, 3'd1);
`else
        add_vec(0, 4'b0101, 3'd2); add_vec(1, 4'b1111, 3'd3); add_vec(2, 4'b1111, 3'd0);
        add_vec(3, 4'b1111, 3'd1); add_vec(4, 4'b1111, 3'd2); add_vec(5, 4'b1111, 3'd3);
        add_vec(6, 4'b1111, 3'd0); add_vec(7, 4'b0001, 3'd0); add_vec(8, 4'b1000, 3'd3);
        add_vec(9, 4'b0110, 3'd1);
`endif
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        @(negedge clk);

        // Single byte with loopback: m_start two edges after req is sampled.
        set_req(1, 8'hA5, 1'b1);
        push_exp(3'd1, 8'hA5);
        @(negedge clk);
        check("single_busy", 32'({busy, grant_idx, m_start}), 32'({1'b1, 3'd1, 1'b0}));
        @(negedge clk);
        check("single_start", 32'(m_start), 32'h1);
        check("single_ack", 32'(req_ack), 32'(4'b0010));
        check("single_tx", 32'(m_tx_byte), 32'hA5);
        req = '0;
        wait_cond("single_ss", 3, 20);
        check("single_cs_n", 32'(cs_n), 32'(4'b1101));
        wait_cond("single_idle", 1, 20);
        rx_xor = 8'h3C;

        // Round-robin / priority vector table, all single-byte bursts.
        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < N; i++) begin
                if (vec[r].mask[i]) set_req(i, 8'(r * 16 + i), 1'b1);
            end
            push_exp(vec[r].exp, 8'(r * 16 + int'(vec[r].exp)) ^ rx_xor);
            wait_cond($sformatf("rr%0d_wait_ack", r), 0, 20);
            check($sformatf("rr%0d_ack", r), 32'(req_ack), 32'(oh(int'(vec[r].exp))));
            check($sformatf("rr%0d_grant", r), 32'(grant_idx), 32'(vec[r].exp));
            req = '0;
            wait_cond($sformatf("rr%0d_idle", r), 1, 30);
        end

        // Burst from requester 2; requester 0 arrives mid-burst and must wait.
        set_req(2, 8'h01, 1'b0);
        push_exp(3'd2, 8'h01 ^ rx_xor);
        wait_cond("burst_wait_ack1", 0, 20);
        check("burst_ack1", 32'(req_ack), 32'(4'b0100));
        set_req(2, 8'h02, 1'b0);
        set_req(0, 8'h55, 1'b1);
        push_exp(3'd2, 8'h02 ^ rx_xor);
        wait_cond("burst_done1", 2, 20);
        @(negedge clk);
        check("burst_gap_nostart", 32'(m_start), 32'h0);
        @(negedge clk);
        check("burst_gap_start", 32'(m_start), 32'h1);
        check("burst_ack2", 32'(req_ack), 32'(4'b0100));
        check("burst_tx2", 32'(m_tx_byte), 32'h02);
        set_req(2, 8'h03, 1'b1);
        push_exp(3'd2, 8'h03 ^ rx_xor);
        wait_cond("burst_wait_ack3", 0, 20);
        check("burst_ack3", 32'(req_ack), 32'(4'b0100));
        check("burst_tx3", 32'(m_tx_byte), 32'h03);
        req[2] = 1'b0;
        push_exp(3'd0, 8'h55 ^ rx_xor);
        wait_cond("burst_wait_ack0", 0, 20);
        check("burst_ack0", 32'(req_ack), 32'(4'b0001));
        req = '0;
        wait_cond("burst_idle", 1, 30);

        // Timeout: requester 3 opens a burst and goes silent.
        set_req(3, 8'h77, 1'b0);
        push_exp(3'd3, 8'h77 ^ rx_xor);
        wait_cond("to_wait_ack", 0, 20);
        check("to_ack", 32'(req_ack), 32'(4'b1000));
        req = '0;
        wait_cond("to_done", 2, 20);
        for (int j = 1; j <= HT + 1; j++) begin
            @(negedge clk);
            if (j == 2) check("to_hold_cs_n", 32'({busy, cs_n}), 32'({1'b1, 4'hF}));
            if (j == HT) check("to_early", 32'(timeout_err), 32'h0);
            if (j == HT + 1) check("to_pulse", 32'({timeout_err, busy}), 32'({4'b1000, 1'b0}));
        end
        set_req(0, 8'h11, 1'b1);
        set_req(3, 8'h33, 1'b1);
        push_exp(3'd0, 8'h11 ^ rx_xor);
        wait_cond("to_ptr_wait", 0, 20);
        check("to_ptr_ack", 32'(req_ack), 32'(4'b0001));
        req = '0;
        wait_cond("to_ptr_idle", 1, 30);

        // Reset while the engine is mid-byte: no response may follow.
        set_req(1, 8'h99, 1'b1);
        wait_cond("rst_wait_ack", 0, 20);
        req = '0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        reset = 1'b0;
        repeat (12) @(negedge clk);
        check("midrst_idle", 32'({busy, rsp_valid}), 32'h0);

        check("sb_empty", 32'(sb.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
